// File: rtl/gf256_pkg.sv
// Shared GF(256) types and constants for the RS decoder's shared arithmetic resources.
// Field polynomial x^8+x^4+x^3+x^2+1 (0x11D).
package gf256_pkg;
    typedef logic [7:0] gf_t;

    localparam gf_t GF_ONE  = 8'h01;
    localparam gf_t GF_ZERO = 8'h00;
    localparam gf_t GF_POLY = 8'h1D;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } inv_arb_state_t;
endpackage

// File: rtl/gf256_inv.sv
// Iterative GF(256) inverter: y = x^254 built as the product of x^2, x^4 .. x^128, one term per cycle.
// No reset: the busy down-counter always drains to zero, so ready self-recovers after power-up.
module gf256_inv
    import gf256_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_start,
    input  logic [7:0] i_x,
    output logic       o_ready,
    output logic [7:0] o_y
);
    logic [2:0] cnt_q;
    gf_t        sq_q;
    gf_t        acc_q;
    gf_t        sq_n;
    gf_t        acc_n;

    gf256_mult u_sq  (.i_a(sq_q),  .i_b(sq_q), .o_p(sq_n));
    gf256_mult u_acc (.i_a(acc_q), .i_b(sq_n), .o_p(acc_n));

    always_ff @(posedge i_clk) begin
        if (i_start) begin
            cnt_q <= 3'd7;
            sq_q  <= i_x;
            acc_q <= GF_ONE;
        end else if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
            sq_q  <= sq_n;
            acc_q <= acc_n;
        end
    end

    assign o_ready = (cnt_q == 3'd0);
    assign o_y     = acc_q;
endmodule

// File: rtl/gf256_mult.sv
// Combinational GF(256) multiplier, shift-and-add with reduction by GF_POLY.
module gf256_mult
    import gf256_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);
    gf_t acc_v;
    gf_t sh_v;

    always_comb begin
        acc_v = GF_ZERO;
        sh_v  = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) acc_v = acc_v ^ sh_v;
            sh_v = sh_v[7] ? ({sh_v[6:0], 1'b0} ^ GF_POLY) : {sh_v[6:0], 1'b0};
        end
        o_p = acc_v;
    end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);
    int k_v;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        k_v   = 0;
        for (int i = 0; i < N; i++) begin
            k_v = (int'(i_ptr) + i) % N;
            if (!o_any && i_req[k_v]) begin
                o_any      = 1'b1;
                o_gnt[k_v] = 1'b1;
                o_idx      = IDW'(k_v);
            end
        end
    end
endmodule

// File: rtl/gf256_inv_arbiter.sv
// Round-robin sharing of one gf256_inv between N_REQ requesters; results tagged with requester id.
// Optional multiply-back check of every result: define GF256_INV_ARB_CHECK_EN.
//   state | meaning
//   IDLE  | accept a request, latch operand/id, advance pointer
//   ISSUE | wait for inverter ready, pulse start
//   WAIT  | guard cycle, then capture y on ready
//   RESP  | register results and o_vld, back to IDLE
module gf256_inv_arbiter
    import gf256_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic               i_clk,
    input  logic               i_resb,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_x,
    output logic [N_REQ-1:0]   o_gnt,
    output logic               o_vld,
    output logic [ID_W-1:0]    o_id,
    output logic [7:0]         o_y,
    output logic               o_zero,
    output logic               o_chk_err,
    output logic               o_busy
);
    inv_arb_state_t  state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, oid_q, oid_d;
    gf_t             op_q, op_d, ycap_q, ycap_d, y_q, y_d;
    logic            opz_q, opz_d, guard_q, guard_d, ozero_q, ozero_d;
    logic            vld_q, vld_d, busy_q, busy_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;
    logic             inv_start;
    logic             inv_ready;
    gf_t              inv_y;

    rr_arbiter #(.N(N_REQ), .IDW(ID_W)) u_arb (
        .i_req (i_req),
        .i_ptr (ptr_q),
        .o_gnt (arb_gnt),
        .o_idx (arb_idx),
        .o_any (arb_any)
    );

    gf256_inv u_inv (
        .i_clk   (i_clk),
        .i_start (inv_start),
        .i_x     (op_q),
        .o_ready (inv_ready),
        .o_y     (inv_y)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        opz_d     = opz_q;
        ycap_d    = ycap_q;
        guard_d   = 1'b0;
        inv_start = 1'b0;
        gnt_d     = '0;
        vld_d     = 1'b0;
        oid_d     = oid_q;
        y_d       = y_q;
        ozero_d   = ozero_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d = arb_gnt;
                    op_d  = i_x[8*arb_idx +: 8];
                    id_d  = arb_idx;
                    ptr_d = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    opz_d = (op_d == GF_ZERO);
                    if (op_d == GF_ZERO) begin
                        ycap_d  = GF_ZERO;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // also drains an inverter left running across a reset
                if (inv_ready) begin
                    inv_start = 1'b1;
                    guard_d   = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!guard_q && inv_ready) begin
                    ycap_d  = inv_y;
                    state_d = RESP;
                end
            end
            RESP: begin
                vld_d   = 1'b1;
                oid_d   = id_q;
                y_d     = ycap_q;
                ozero_d = opz_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= GF_ZERO;
            opz_q   <= 1'b0;
            ycap_q  <= GF_ZERO;
            guard_q <= 1'b0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            oid_q   <= '0;
            y_q     <= GF_ZERO;
            ozero_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            opz_q   <= opz_d;
            ycap_q  <= ycap_d;
            guard_q <= guard_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            oid_q   <= oid_d;
            y_q     <= y_d;
            ozero_q <= ozero_d;
            busy_q  <= busy_d;
        end
    end

`ifdef GF256_INV_ARB_CHECK_EN
    gf_t  prod;
    logic chk_q;

    gf256_mult u_mult (.i_a(op_q), .i_b(ycap_q), .o_p(prod));

    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            chk_q <= 1'b0;
        end else if (state_q == RESP) begin
            chk_q <= !opz_q && (prod != GF_ONE);
        end
    end

    assign o_chk_err = chk_q;
`else
    assign o_chk_err = 1'b0;
`endif

    assign o_gnt  = gnt_q;
    assign o_vld  = vld_q;
    assign o_id   = oid_q;
    assign o_y    = y_q;
    assign o_zero = ozero_q;
    assign o_busy = busy_q;
endmodule

// File: tb/tb_gf256_inv_arbiter.sv
// Directed bench for gf256_inv_arbiter (N_REQ=2 and N_REQ=3 instances).
module tb_gf256_inv_arbiter;
    localparam int LAT = 10;   // 3 + inverter busy time of 7

    logic        clk;
    logic        resb;
    logic [1:0]  req;
    logic [15:0] x;
    logic [1:0]  gnt;
    logic        vld, id, zero, chk, busy;
    logic [7:0]  y;

    logic [2:0]  req3;
    logic [23:0] x3;
    logic [2:0]  gnt3;
    logic        vld3, zero3, chk3, busy3;
    logic [1:0]  id3;
    logic [7:0]  y3;

    int n_chk, n_pass, n_fail;
    int n_start, gnt_busy_viol;
    logic busy_prev;
    logic [7:0] inv_tab [256];

    gf256_inv_arbiter #(.N_REQ(2), .ID_W(1)) dut (
        .i_clk(clk), .i_resb(resb), .i_req(req), .i_x(x),
        .o_gnt(gnt), .o_vld(vld), .o_id(id), .o_y(y),
        .o_zero(zero), .o_chk_err(chk), .o_busy(busy)
    );

    gf256_inv_arbiter #(.N_REQ(3), .ID_W(2)) dut3 (
        .i_clk(clk), .i_resb(resb), .i_req(req3), .i_x(x3),
        .o_gnt(gnt3), .o_vld(vld3), .o_id(id3), .o_y(y3),
        .o_zero(zero3), .o_chk_err(chk3), .o_busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (dut.inv_start) n_start++;
        if (gnt != 2'b00 && busy_prev) gnt_busy_viol++;
        busy_prev = busy;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1D) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output logic [1:0] g, output int cyc);
        g = 2'b00;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (gnt != 2'b00) begin
                g = gnt;
                break;
            end
        end
    endtask

    task automatic wait_gnt3(output logic [2:0] g, output int cyc);
        g = 3'b000;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (gnt3 != 3'b000) begin
                g = gnt3;
                break;
            end
        end
    endtask

    task automatic wait_vld(output int cyc);
        cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (vld) break;
        end
    endtask

    initial begin
        logic [1:0] g;
        logic [2:0] g3;
        int c, s0, nv, bad_chk;
        logic [7:0] yv;

        n_chk = 0; n_pass = 0; n_fail = 0;
        n_start = 0; gnt_busy_viol = 0; busy_prev = 1'b0;
        for (int a = 0; a < 256; a++) begin
            inv_tab[a] = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
        end

        resb = 1'b0; req = 2'b00; x = 16'h0; req3 = 3'b000; x3 = 24'h0;
        repeat (10) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_vld", vld, 0);
        check("rst_id", id, 0);
        check("rst_y", y, 0);
        check("rst_zero", zero, 0);
        check("rst_chk", chk, 0);
        check("rst_busy", {busy, busy3}, 0);
        resb = 1'b1;
        @(negedge clk);

        // requester 0 alone, x=0x02
        x = 16'h0002; req = 2'b01;
        wait_gnt(g, c);
        check("t1_gnt", g, 2'b01);
        check("t1_gnt_lat", c, 1);
        check("t1_busy", busy, 1);
        req = 2'b00;
        wait_vld(c);
        check("t1_vld_lat", c, LAT);
        check("t1_id", id, 0);
        check("t1_y", y, 8'h8E);
        check("t1_zero", zero, 0);
        check("t1_chk", chk, 0);
        @(negedge clk);
        check("t1_vld_pulse", vld, 0);
        check("t1_y_hold", y, 8'h8E);

        // requester 1, zero operand (pointer now 1)
        s0 = n_start;
        x = 16'h0000; req = 2'b10;
        wait_gnt(g, c);
        check("t3_gnt", g, 2'b10);
        req = 2'b00;
        @(negedge clk);
        check("t3_vld", vld, 1);
        check("t3_id", id, 1);
        check("t3_y", y, 8'h00);
        check("t3_zero", zero, 1);
        check("t3_chk", chk, 0);
        check("t3_no_start", n_start - s0, 0);

        // both requesters held (pointer now 0)
        x = 16'h5303; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(g, c);
            check("t2_gnt", g, (k % 2 == 1) ? 2'b10 : 2'b01);
            if (k > 0) check("t2_gap", c, 1);
            if (k == 3) req = 2'b00;
            wait_vld(c);
            check("t2_lat", c, LAT);
            check("t2_id", id, k % 2);
            check("t2_y", y, (k % 2 == 1) ? inv_tab[8'h53] : 8'hF4);
        end
        check("t2_gnt_while_busy", gnt_busy_viol, 0);

        // sweep all nonzero operands through requester 0
        bad_chk = 0;
        nv = 0;
        for (int v = 1; v < 256; v++) begin
            x = {8'h00, 8'(v)}; req = 2'b01;
            wait_gnt(g, c);
            req = 2'b00;
            wait_vld(c);
            if (vld) nv++;
            if (chk) bad_chk++;
            check($sformatf("sweep_y_%02h", v), y, inv_tab[v]);
        end
        check("sweep_vld_count", nv, 255);
        check("sweep_chk_err", bad_chk, 0);

`ifdef GF256_INV_ARB_CHECK_EN
        force dut.inv_y = 8'h00;
        x = 16'h0007; req = 2'b01;
        wait_gnt(g, c);
        req = 2'b00;
        wait_vld(c);
        check("forced_chk_err", chk, 1);
        release dut.inv_y;
`endif

        // reset while in WAIT
        x = 16'h0009; req = 2'b01;
        wait_gnt(g, c);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("t5_in_wait", busy, 1);
        resb = 1'b0;
        #1;
        check("t5_rst_outs", {gnt, vld, id, y, zero, chk}, 0);
        check("t5_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        resb = 1'b1;
        x = 16'h0005; req = 2'b01;
        nv = 0; yv = 8'h00;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) req = 2'b00;
            if (vld) begin
                nv++;
                yv = y;
            end
        end
        check("t5_vld_count", nv, 1);
        check("t5_y", yv, inv_tab[8'h05]);

        // N_REQ=3: move pointer to 2, then hold 1 and 2
        x3 = 24'h0; req3 = 3'b010;
        wait_gnt3(g3, c);
        check("t6_first", g3, 3'b010);
        req3 = 3'b000;
        repeat (3) @(negedge clk);
        req3 = 3'b110;
        for (int k = 0; k < 3; k++) begin
            wait_gnt3(g3, c);
            check("t6_gnt", g3, (k == 1) ? 3'b010 : 3'b100);
            if (k == 2) req3 = 3'b000;
            @(negedge clk);
            check("t6_id", {vld3, id3}, (k == 1) ? 3'b101 : 3'b110);
            check("t6_zero_y", {zero3, chk3, y3}, 10'h200);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
